// File: rtl/addsub_pipe_if.sv
// Operand/result bundle for addsub_pipe. With ADDSUB_SAT_EN defined, a `sat` request
// travels alongside each op.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

interface addsub_pipe_if #(
  parameter int unsigned WIDTH = `LEN_DATA
);
  logic             en;
  logic             hold;
  logic             op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSUB_SAT_EN
  logic             sat;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             rdy;

  modport master (
`ifdef ADDSUB_SAT_EN
    output sat,
`endif
    output en, hold, op, cin, a, b,
    input  sum, cout, ovf, rdy
  );

  modport slave (
`ifdef ADDSUB_SAT_EN
    input  sat,
`endif
    input  en, hold, op, cin, a, b,
    output sum, cout, ovf, rdy
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one carry chunk per stage, one op per cycle, latency STAGES-1
// edges. Defining ADDSUB_SAT_EN adds a per-op saturate-on-overflow request.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

module addsub_pipe #(
  parameter int unsigned WIDTH  = `LEN_DATA,
  parameter int unsigned STAGES = 4
) (
  input logic          clk,
  input logic          rst,
  addsub_pipe_if.slave bus
);

  localparam int unsigned ChunkW = WIDTH / STAGES;

  // Per-rank state: operands travel in full, the partial sum fills in one chunk per rank.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bp_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] bp_in [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d;
  logic [ChunkW:0]  chunk;

`ifdef ADDSUB_SAT_EN
  logic             sat_q [STAGES];
  logic             sat_in[STAGES];
`endif

  always_comb begin
    chunk = '0;
    // Subtraction is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
    a_in[0]  = bus.a;
    bp_in[0] = bus.op ? ~bus.b : bus.b;
    s_in[0]  = '0;
    c_in[0]  = bus.op ^ bus.cin;
    v_in[0]  = bus.en;
`ifdef ADDSUB_SAT_EN
    sat_in[0] = bus.sat;
`endif
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k]  = a_q[k-1];
      bp_in[k] = bp_q[k-1];
      s_in[k]  = s_q[k-1];
      c_in[k]  = c_q[k-1];
      v_in[k]  = v_q[k-1];
`ifdef ADDSUB_SAT_EN
      sat_in[k] = sat_q[k-1];
`endif
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_in[k][k*ChunkW +: ChunkW]} + {1'b0, bp_in[k][k*ChunkW +: ChunkW]}
            + {{ChunkW{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*ChunkW +: ChunkW] = chunk[ChunkW-1:0];
      c_d[k] = chunk[ChunkW];
    end

    ovf_d = (a_in[STAGES-1][WIDTH-1] == bp_in[STAGES-1][WIDTH-1]) &&
            (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    // Equal operand signs on overflow: a negative A means the true result was too negative.
    if (sat_in[STAGES-1] && ovf_d) begin
      s_d[STAGES-1] = a_in[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        bp_q[k] <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
`ifdef ADDSUB_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
    end else if (!bus.hold) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        // Data only moves with a valid op, so outputs keep their last value across bubbles.
        if (v_in[k]) begin
          a_q[k]  <= a_in[k];
          bp_q[k] <= bp_in[k];
          s_q[k]  <= s_d[k];
          c_q[k]  <= c_d[k];
`ifdef ADDSUB_SAT_EN
          sat_q[k] <= sat_in[k];
`endif
        end
      end
      if (v_in[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.sum  = s_q[STAGES-1];
  assign bus.cout = c_q[STAGES-1];
  assign bus.ovf  = ovf_q;
  assign bus.rdy  = v_q[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: three depths (4, 1, 8) share one stimulus stream and
// are each checked against an exact-arithmetic reference model.
module tb_addsub_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        hold;
  logic        op;
  logic        cin;
  logic        sat;
  logic [63:0] a;
  logic [63:0] b;
  logic        done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Exact signed / unsigned arithmetic; no knowledge of chunks or pipeline.
  function automatic exp_t model(input logic o, input logic ci, input logic s,
                                 input logic [63:0] x, input logic [63:0] y);
    exp_t             e;
    logic signed [65:0] sr;
    logic [65:0]        ur;
    if (!o) begin
      sr = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
      ur = {2'b00, x} + {2'b00, y} + {65'd0, ci};
      e.cout = ur[64];
    end else begin
      sr = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, ci});
      e.cout = ({2'b00, x} >= ({2'b00, y} + {65'd0, ci}));
    end
    e.sum = sr[63:0];
    e.ovf = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
    if (s && e.ovf) e.sum = sr[65] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    e.due = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    addsub_pipe_if #(.WIDTH(64)) bus ();

    assign bus.en   = en;
    assign bus.hold = hold;
    assign bus.op   = op;
    assign bus.cin  = cin;
    assign bus.a    = a;
    assign bus.b    = b;
`ifdef ADDSUB_SAT_EN
    assign bus.sat  = sat;
`endif

    addsub_pipe #(.WIDTH(64), .STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    exp_t        q[$];
    int unsigned act_cnt   = 0;
    logic [63:0] last_sum  = '0;
    logic        last_cout = 1'b0;
    logic        last_ovf  = 1'b0;
    logic        last_rdy  = 1'b0;

    always @(negedge rst) q.delete();

    initial begin
      #20;
      chk($sformatf("s%0d_rst_rdy", S), bus.rdy, 0);
      chk($sformatf("s%0d_rst_sum", S), bus.sum, 0);
      chk($sformatf("s%0d_rst_cout", S), bus.cout, 0);
      chk($sformatf("s%0d_rst_ovf", S), bus.ovf, 0);
    end

    always @(posedge clk) begin
      exp_t e;
      logic adv;
      adv = rst && !hold;
      if (adv) begin
        act_cnt++;
        if (en) begin
          e = model(op, cin, sat, a, b);
          e.due = act_cnt + S - 1;
          q.push_back(e);
        end
      end
      #1;
      if (rst) begin
        if (!adv) begin
          chk($sformatf("s%0d_hold_rdy", S), bus.rdy, last_rdy);
          chk($sformatf("s%0d_hold_sum", S), bus.sum, last_sum);
          chk($sformatf("s%0d_hold_flags", S), {bus.cout, bus.ovf}, {last_cout, last_ovf});
        end else if (bus.rdy) begin
          if (q.size() == 0) begin
            chk($sformatf("s%0d_spurious_rdy", S), bus.rdy, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("s%0d_sum", S), bus.sum, e.sum);
            chk($sformatf("s%0d_cout", S), bus.cout, e.cout);
            chk($sformatf("s%0d_ovf", S), bus.ovf, e.ovf);
            chk($sformatf("s%0d_latency", S), act_cnt, e.due);
          end
        end else begin
          chk($sformatf("s%0d_bubble_sum", S), bus.sum, last_sum);
          if (q.size() != 0 && q[0].due <= act_cnt)
            chk($sformatf("s%0d_missing_rdy", S), bus.rdy, 1);
        end
      end
      last_sum  = bus.sum;
      last_cout = bus.cout;
      last_ovf  = bus.ovf;
      last_rdy  = bus.rdy;
    end

    initial begin
      wait (done);
      chk($sformatf("s%0d_drain", S), q.size(), 0);
    end
  end

  task automatic issue(input logic o, input logic ci, input logic s,
                       input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    en = 1'b1; hold = 1'b0; op = o; cin = ci; sat = s; a = x; b = y;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; hold = 1'b0;
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h0;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; hold = 1'b0; op = 1'b0; cin = 1'b0; sat = 1'b0;
    a = '0; b = '0; done = 1'b0;
    #34 rst = 1'b1;

    issue(0, 0, 0, 64'd912, 64'd65);
    idle(10);

    issue(0, 0, 0, 64'd768, 64'd65);
    issue(0, 0, 0, 64'd65, 64'd65);
    issue(0, 0, 0, 64'd456, 64'd999);
    issue(0, 0, 0, 64'd6234, 64'd90213);
    idle(10);

    issue(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    issue(1, 0, 0, 64'd65, 64'd65);
    issue(1, 0, 0, 64'd64, 64'd65);
    issue(1, 1, 0, 64'd0, 64'd0);
    issue(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    issue(0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    issue(0, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1, 0, 0, 64'h8000_0000_0000_0000, 64'd1);
`ifdef ADDSUB_SAT_EN
    issue(0, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    issue(0, 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    idle(10);

    // Stall for three cycles in the middle of a stream.
    for (int i = 0; i < 10; i++) begin
      issue($urandom_range(0, 1), $urandom_range(0, 1), 0, pick(), pick());
      hold = (i >= 3 && i < 6);
    end
    idle(10);

    // Asynchronous reset with ops in flight.
    for (int i = 0; i < 5; i++) issue(0, 0, 0, pick(), pick());
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rdy_s4", g_dut[0].bus.rdy, 0);
    chk("mid_rst_rdy_s1", g_dut[1].bus.rdy, 0);
    chk("mid_rst_rdy_s8", g_dut[2].bus.rdy, 0);
    chk("mid_rst_sum_s8", g_dut[2].bus.sum, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(12);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 7) == 0);
      op   = $urandom_range(0, 1);
      cin  = $urandom_range(0, 1);
      a    = pick();
      b    = pick();
`ifdef ADDSUB_SAT_EN
      sat  = $urandom_range(0, 1);
`endif
    end
    idle(15);

    done = 1'b1;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
